// File: rtl/mips_pkg.sv
// mips_pkg
// Shared definitions for the MIPS core pipeline blocks.
//   MIPS_DATA_W / MIPS_ADDR_W / MIPS_REG_W : default datapath, byte address and
//                                           register index widths
//   mem_state_e                           : MEM stage sequencer states
package mips_pkg;

  localparam int MIPS_DATA_W = 32;
  localparam int MIPS_ADDR_W = 32;
  localparam int MIPS_REG_W  = 5;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } mem_state_e;

endpackage

// File: rtl/mem_stage_ctrl_if.sv
// mem_stage_ctrl_if
// Handshaked data-memory bus between the MEM stage controller and data memory.
//   mem_req   : request held high until the access completes
//   mem_we    : 1 = write, 0 = read
//   mem_addr  : word-aligned byte address
//   mem_wdata : store data
//   mem_ack   : one-cycle completion strobe from memory
//   mem_rdata : read data, valid together with mem_ack
// Modports: master (controller side), slave (memory side).
interface mem_stage_ctrl_if
  import mips_pkg::*;
#(
  parameter int ADDR_W = MIPS_ADDR_W,
  parameter int DATA_W = MIPS_DATA_W
);

  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_ack;
  logic [DATA_W-1:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_ack, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_ack, mem_rdata
  );

endinterface

// File: rtl/mem_timeout_cnt.sv
// mem_timeout_cnt
// Counts cycles a memory request has waited for its acknowledge.
//   clk, rst_n : clock, asynchronous active-low reset
//   clear      : synchronous clear (priority over enable)
//   enable     : advance the count by one this cycle
//   tc         : count has reached TIMEOUT_CYC-1
module mem_timeout_cnt #(
  parameter int TIMEOUT_CYC = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic tc
);

  localparam int CNT_W = $clog2(TIMEOUT_CYC);
  localparam logic [CNT_W-1:0] TC_VAL = CNT_W'(TIMEOUT_CYC - 1);

  logic [CNT_W-1:0] count;

  // Saturates at the terminal value so tc can never wrap back to 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && (count != TC_VAL)) begin
      count <= count + CNT_W'(1);
    end
  end

  assign tc = (count == TC_VAL);

endmodule

// File: rtl/mem_stage_ctrl.sv
// mem_stage_ctrl
// MEM pipeline stage controller: issues loads/stores on a handshaked data
// memory, stalls upstream while an access is outstanding and loads MEM/WB.
//   clk, rst_n     : clock, asynchronous active-low reset
//   in_*           : EX/MEM instruction (valid, read, write, reg_write, rd,
//                    ALU result / byte address, store data)
//   stall          : combinational, upstream holds EX/MEM while high
//   mem            : data-memory bus (master modport)
//   wb_*           : MEM/WB valid, write enable, register and data
//   err            : sticky misalignment / conflict / timeout flag
module mem_stage_ctrl
  import mips_pkg::*;
#(
  parameter int DATA_W      = MIPS_DATA_W,
  parameter int ADDR_W      = MIPS_ADDR_W,
  parameter int REG_W       = MIPS_REG_W,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic              in_mem_read,
  input  logic              in_mem_write,
  input  logic              in_reg_write,
  input  logic [REG_W-1:0]  in_rd,
  input  logic [DATA_W-1:0] in_alu_result,
  input  logic [DATA_W-1:0] in_wdata,
  output logic              stall,
  mem_stage_ctrl_if.master  mem,
  output logic              wb_valid,
  output logic              wb_reg_write,
  output logic [REG_W-1:0]  wb_rd,
  output logic [DATA_W-1:0] wb_data,
  output logic              err
);

  mem_state_e        state;
  logic              is_mem;
  logic              bad;
  logic              busy;
  logic              tc;
  logic              timeout;
  logic              done;
  logic [ADDR_W-1:0] addr_src;

  assign is_mem   = in_mem_read | in_mem_write;
  assign bad      = is_mem & ((in_alu_result[1:0] != 2'b00) | (in_mem_read & in_mem_write));
  assign busy     = (state == BUSY);
  assign timeout  = busy & tc;
  // Ack has priority over timeout, but both end the access this cycle.
  assign done     = busy & (mem.mem_ack | timeout);
  assign stall    = in_valid & is_mem & ~bad & ~done;
  assign addr_src = ADDR_W'(in_alu_result);

  // Counter is held clear while idle, so it starts at 0 on the first request cycle.
  mem_timeout_cnt #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_timeout_cnt (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (~busy),
    .enable (busy & ~mem.mem_ack),
    .tc     (tc)
  );

  // Write enable is gated along with wb_valid whenever MEM/WB is empty.
  // During BUSY the upstream stage is stalled, so in_rd/in_alu_result still
  // describe the in-flight instruction when the access completes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      mem.mem_req   <= 1'b0;
      mem.mem_we    <= 1'b0;
      mem.mem_addr  <= '0;
      mem.mem_wdata <= '0;
      wb_valid      <= 1'b0;
      wb_reg_write  <= 1'b0;
      wb_rd         <= '0;
      wb_data       <= '0;
      err           <= 1'b0;
    end else begin
      wb_valid     <= 1'b0;
      wb_reg_write <= 1'b0;
      case (state)
        IDLE: begin
          if (in_valid) begin
            if (!is_mem) begin
              wb_valid     <= 1'b1;
              wb_reg_write <= in_reg_write;
              wb_rd        <= in_rd;
              wb_data      <= in_alu_result;
            end else if (bad) begin
              wb_valid <= 1'b1;
              err      <= 1'b1;
            end else begin
              mem.mem_req   <= 1'b1;
              mem.mem_we    <= in_mem_write;
              mem.mem_addr  <= {addr_src[ADDR_W-1:2], 2'b00};
              mem.mem_wdata <= in_wdata;
              state         <= BUSY;
            end
          end
        end
        BUSY: begin
          if (mem.mem_ack) begin
            mem.mem_req  <= 1'b0;
            wb_valid     <= 1'b1;
            wb_reg_write <= in_reg_write;
            wb_rd        <= in_rd;
            wb_data      <= mem.mem_we ? in_alu_result : mem.mem_rdata;
            state        <= IDLE;
          end else if (timeout) begin
            mem.mem_req <= 1'b0;
            wb_valid    <= 1'b1;
            err         <= 1'b1;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
